// File: rtl/uart_rx_buffered_pkg.sv
// Shared definitions for the buffered UART receiver: FSM encoding and bit timing.
package uart_rx_buffered_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    WAIT_HIGH = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } rx_state_t;

  // Clock cycles per serial bit (integer division).
  function automatic int unsigned bit_cycles(input int unsigned clk_hz,
                                             input int unsigned sclk_hz);
    return clk_hz / sclk_hz;
  endfunction

  // Clock cycles from the start-bit edge to the middle of the start bit.
  function automatic int unsigned half_cycles(input int unsigned clk_hz,
                                              input int unsigned sclk_hz);
    return bit_cycles(clk_hz, sclk_hz) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO: extra-MSB pointers, combinational head, drops pushes when full
// unless a pop frees the slot in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic [7:0]            mem [DEPTH];
  logic                  do_pop;
  logic                  do_push;

  // Occupancy flags from pointer comparison
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
              (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    do_pop  = pop && !empty;
    // When full, the slot under rd_ptr is the one being written, so a
    // simultaneous pop makes the push legal.
    do_push = push && (!full || do_pop);
    head    = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];
  end

  // Pointer update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with synchronizer, mid-bit sampling FSM and receive FIFO.
module uart_rx_buffered
  import uart_rx_buffered_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 40000000,
  parameter int unsigned SCLK_HZ         = 115200,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_rxd,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned BIT_CYC  = bit_cycles(CLK_HZ, SCLK_HZ);
  localparam int unsigned HALF_CYC = half_cycles(CLK_HZ, SCLK_HZ);
  localparam int unsigned CNT_W    = $clog2(BIT_CYC + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

  logic [1:0]       sync;
  logic             rxs;
  rx_state_t        state;
  rx_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             cnt_done;
  logic             cnt_run;
  logic             shift_en;
  logic             push;
  logic             frame_bad;
  logic             full;
  logic             empty;

  // Two-flop synchronizer for the asynchronous serial line (idles high)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= '1;
    else          sync <= {sync[0], uart_rxd};
  end

  assign rxs = sync[1];

  // Sample-point detection: half a bit in START, a full bit elsewhere
  always_comb begin
    cnt_done = (state == START) ? (cnt == HALF_LAST) : (cnt == BIT_LAST);
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= WAIT_HIGH;
    else          state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      WAIT_HIGH: if (rxs)  state_next = IDLE;
      IDLE:      if (!rxs) state_next = START;
      START:     if (cnt_done) state_next = rxs ? IDLE : DATA;
      DATA:      if (cnt_done && (bit_idx == 3'(DATA_BITS - 1))) state_next = STOP;
      STOP:      if (cnt_done) state_next = rxs ? IDLE : WAIT_HIGH;
      default:   state_next = WAIT_HIGH;
    endcase
  end

  // FSM outputs: counter enable, shift strobe, push and framing error
  always_comb begin
    cnt_run   = 1'b0;
    shift_en  = 1'b0;
    push      = 1'b0;
    frame_bad = 1'b0;
    unique case (state)
      START: cnt_run = 1'b1;
      DATA: begin
        cnt_run  = 1'b1;
        shift_en = cnt_done;
      end
      STOP: begin
        cnt_run   = 1'b1;
        push      = cnt_done && rxs;
        frame_bad = cnt_done && !rxs;
      end
      default: ;
    endcase
  end

  // Bit-period counter; restarts at every sample point and outside a frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                cnt <= '0;
    else if (!cnt_run || cnt_done) cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end

  // Data bit index and LSB-first shift register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else if (state == IDLE) begin
      bit_idx <= '0;
    end else if (shift_en) begin
      bit_idx <= bit_idx + 1'b1;
      shreg   <= {rxs, shreg[7:1]};
    end
  end

  // Registered status pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      overrun   <= push && full && !(data_ready && !empty);
    end
  end

  uart_rx_fifo #(
    .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_data(shreg),
    .pop      (data_ready),
    .head     (data_out),
    .full     (full),
    .empty    (empty)
  );

  assign data_valid = !empty;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: driver models frames and FIFO occupancy,
// a negedge monitor pops the expected queue on every DUT pop.
module tb_uart_rx_buffered;

  localparam int CLK_HZ     = 40000000;
  localparam int SCLK_HZ    = 115200;
  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int BIT        = CLK_HZ / SCLK_HZ;
  localparam int HALF       = BIT / 2;
  // Edge, counted from the first edge that sees the start bit, on which the
  // stop bit is sampled: two synchronizer stages, one cycle to leave IDLE,
  // half a bit, eight data bits and the stop bit.
  localparam int STOP_EDGE  = 3 + HALF + 9 * BIT;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;

  uart_rx_buffered #(
    .CLK_HZ(CLK_HZ),
    .SCLK_HZ(SCLK_HZ),
    .FIFO_DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .uart_rxd(uart_rxd),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int exp_ferr = 0;
  int exp_ovr  = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_valid = 0;
  int n_pop = 0;
  logic [7:0] last_pop = '0;
  logic held_valid = 1'b0;
  logic [7:0] held_data = '0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: counts pulses and pops, compares each popped byte to the model
  always @(negedge clk) begin
    if (!reset_n) begin
      held_valid = 1'b0;
    end else begin
      if (frame_err)  n_ferr++;
      if (overrun)    n_ovr++;
      if (data_valid) n_valid++;
      if (data_valid && held_valid) check("head_stable", data_out, held_data);
      if (data_valid && data_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got 0x%0h, required no byte", data_out);
        end else begin
          last_pop = exp_q.pop_front();
          check("pop_data", data_out, last_pop);
        end
        held_valid = 1'b0;
      end else begin
        held_valid = data_valid;
        held_data  = data_out;
      end
    end
  end

  function automatic logic pick_ready(input int mode, input bit at_stop);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return ($urandom_range(0, 1) == 1);
      default: return at_stop;
    endcase
  endfunction

  // One clock of stimulus; the values are seen by the next rising edge
  task automatic step(input logic rxd, input logic rdy);
    @(posedge clk);
    #1;
    uart_rxd   = rxd;
    data_ready = rdy;
  endtask

  task automatic idle(input int n, input logic rxd, input int mode);
    for (int i = 0; i < n; i++) step(rxd, pick_ready(mode, 1'b0));
  endtask

  // Behavioural outcome of a completed frame at its stop sample
  task automatic model_stop(input logic [7:0] b, input logic stop_bit, input logic rdy);
    if (!stop_bit)                            exp_ferr++;
    else if (exp_q.size() == DEPTH && !rdy)   exp_ovr++;
    else                                      exp_q.push_back(b);
  endtask

  // Sends one 8N1 frame; mode selects data_ready behaviour, abort_at pulses reset
  task automatic send(input logic [7:0] b, input logic stop_bit, input int mode,
                      input int abort_at);
    logic [9:0] frame;
    logic       rdy;
    bit         aborted;
    frame   = {stop_bit, b, 1'b0};
    aborted = 1'b0;
    for (int c = 0; c < 10 * BIT; c++) begin
      rdy = pick_ready(mode, c == STOP_EDGE - 1);
      step(frame[c / BIT], rdy);
      if (c == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("abort_data_out", data_out, 0);
        check("abort_data_valid", data_valid, 0);
        check("abort_frame_err", frame_err, 0);
        check("abort_overrun", overrun, 0);
        exp_q.delete();
        aborted = 1'b1;
      end
      if (aborted && c == abort_at + 3) reset_n = 1'b1;
      if (c == STOP_EDGE - 1 && !aborted) model_stop(b, stop_bit, rdy);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int v0, p0, o0;
    logic [7:0] rb;
    logic       rs;

    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", data_out, 0);
    check("reset_data_valid", data_valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    reset_n = 1'b1;
    idle(20, 1'b1, 1);

    // Single byte, consumer always ready
    v0 = n_valid;
    send(8'hA5, 1'b1, 1, -1);
    idle(50, 1'b1, 1);
    check("a5_valid_cycles", n_valid - v0, 1);
    check("a5_last_pop", last_pop, 8'hA5);
    check("a5_frame_err", n_ferr, exp_ferr);

    // Short low glitch is rejected, next byte received
    v0 = n_valid;
    idle(100, 1'b0, 1);
    idle(400, 1'b1, 1);
    send(8'h3C, 1'b1, 1, -1);
    idle(50, 1'b1, 1);
    check("glitch_valid_cycles", n_valid - v0, 1);
    check("glitch_last_pop", last_pop, 8'h3C);
    check("glitch_frame_err", n_ferr, exp_ferr);

    // Bad stop bit followed by a long break, then a clean byte
    p0 = n_pop;
    send(8'h55, 1'b0, 1, -1);
    idle(5000, 1'b0, 1);
    idle(2 * BIT, 1'b1, 1);
    send(8'h01, 1'b1, 1, -1);
    idle(50, 1'b1, 1);
    check("break_frame_err", n_ferr, exp_ferr);
    check("break_pops", n_pop - p0, 1);
    check("break_last_pop", last_pop, 8'h01);

    // Fill with consumer stalled; fifth byte overruns
    p0 = n_pop;
    for (int i = 0; i < 5; i++) begin
      send(8'(i), 1'b1, 0, -1);
      idle(30, 1'b1, 0);
    end
    check("fill_overrun", n_ovr, exp_ovr);
    check("fill_valid", data_valid, 1);
    check("fill_head", data_out, 8'h00);
    idle(20, 1'b1, 1);
    check("fill_pops", n_pop - p0, 4);
    check("fill_last_pop", last_pop, 8'h03);

    // Push into a full FIFO with a pop on the same edge
    p0 = n_pop;
    o0 = n_ovr;
    for (int i = 0; i < 4; i++) begin
      send(8'h10 + 8'(i), 1'b1, 0, -1);
      idle(30, 1'b1, 0);
    end
    send(8'hEE, 1'b1, 3, -1);
    idle(30, 1'b1, 0);
    check("fullpop_overrun", n_ovr - o0, 0);
    idle(20, 1'b1, 1);
    check("fullpop_pops", n_pop - p0, 5);
    check("fullpop_last_pop", last_pop, 8'hEE);

    // Randomized bytes, stop bits and consumer behaviour
    for (int k = 0; k < 3; k++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      send(rb, rs, 2, -1);
      idle($urandom_range(20, 200), 1'b1, 2);
    end
    rb = 8'($urandom_range(0, 255));
    send(rb, 1'b1, 0, -1);
    idle(30, 1'b1, 0);
    check("prereset_valid", data_valid, (exp_q.size() != 0) ? 1 : 0);
    check("prereset_frame_err", n_ferr, exp_ferr);

    // Reset in the middle of a frame, then a clean byte
    p0 = n_pop;
    send(8'hFF, 1'b1, 0, 4 * BIT + 100);
    idle(50, 1'b1, 0);
    check("postabort_valid", data_valid, 0);
    idle(20, 1'b1, 1);
    send(8'h7E, 1'b1, 1, -1);
    idle(50, 1'b1, 1);
    check("postabort_pops", n_pop - p0, 1);
    check("postabort_last_pop", last_pop, 8'h7E);

    check("final_queue_drained", exp_q.size(), 0);
    check("final_frame_err", n_ferr, exp_ferr);
    check("final_overrun", n_ovr, exp_ovr);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
